bcd_scan_driver: RTL and testbench

BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

---
 rtl/bcd_scan_driver.sv | 114 +++++++++++
 tb/tb_bcd_scan_driver.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bcd_scan_driver.sv
// Multiplexed BCD display scanner: BLANK/SHOW per digit, frame-synchronous display update.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always lit).
module bcd_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_end
);
    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] display_q, display_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic [3:0]              bcd_out_q, bcd_out_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    frame_end_q, frame_end_d;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]   lz;
    logic                    acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            display_q   <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            bcd_out_q   <= '0;
            digit_sel_q <= '0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            display_q   <= display_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            bcd_out_q   <= bcd_out_d;
            digit_sel_q <= digit_sel_d;
            frame_end_q <= frame_end_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        display_d = display_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;

        case (state_q)
            BLANK: if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                state_d = SHOW;
                cnt_d   = '0;
            end
            default: if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                state_d = BLANK;
                cnt_d   = '0;
                idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
            end
        endcase

        // frame_end_q marks the current cycle as the last of the frame,
        // so the display only ever changes on a frame boundary.
        if (frame_end_q) begin
            if (load)           display_d = digits_in;
            else if (pending_q) display_d = shadow_q;
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = digits_in;
            pending_d = 1'b1;
        end

        // Outputs are registered from the next-state decode so they line up with the state.
        bcd_out_d   = display_d[{idx_d, 2'b00} +: 4];
        digit_sel_d = (state_d == SHOW) ? (NUM_DIGITS'(1) << idx_d) : '0;
        frame_end_d = (state_d == SHOW) && (cnt_d == CW'(DWELL_CYCLES - 1)) &&
                      (idx_d == IW'(NUM_DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
        acc = 1'b1;
        lz  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc   = acc & (display_d[4*i +: 4] == 4'h0);
            lz[i] = acc;
        end
        if (idx_d != '0 && lz[idx_d]) begin
            bcd_out_d   = 4'hF;
            digit_sel_d = '0;
        end
`endif
    end

    assign bcd_out   = bcd_out_q;
    assign digit_sel = digit_sel_q;
    assign frame_end = frame_end_q;
endmodule

// File: tb/tb_bcd_scan_driver.sv
// Randomized bench for bcd_scan_driver against a frame-level reference model.
module tb_bcd_scan_driver;
    localparam int ND = 4, DW = 4, BK = 2;
    localparam int SLOT = DW + BK, FRAME = ND * SLOT;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     digits_in = '0;
    logic            load = 1'b0;
    logic [3:0]      bcd_out;
    logic [ND-1:0]   digit_sel;
    logic            frame_end;

    bcd_scan_driver #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BK)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
        .bcd_out(bcd_out), .digit_sel(digit_sel), .frame_end(frame_end));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int t;                       // cycle number since reset release
    logic [15:0] m_disp, m_shadow;
    logic        m_pend;
    logic [15:0] sched [int];    // directed loads keyed by cycle number
    bit          rnd_en = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        m_disp = '0; m_shadow = '0; m_pend = 1'b0; t = 0;
    endtask

    // Expected outputs from cycle position within the frame.
    task automatic check_outputs();
        int pos, slot, nib;
        bit show, sup;
        pos  = t % FRAME;
        slot = pos / SLOT;
        show = (pos % SLOT) >= BK;
        nib  = (m_disp >> (4 * slot)) & 4'hF;
        sup  = 0;
`ifdef LEADING_ZERO_BLANK_EN
        sup  = (slot > 0) && ((m_disp >> (4 * slot)) == 0);
`endif
        chk("bcd_out",   32'(bcd_out),   sup ? 32'hF : 32'(nib));
        chk("digit_sel", 32'(digit_sel), (show && !sup) ? 32'(1 << slot) : 32'd0);
        chk("frame_end", 32'(frame_end), 32'(pos == FRAME - 1));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_outputs();
            load = 1'b0;
            if (sched.exists(t)) begin
                load = 1'b1; digits_in = sched[t];
            end else if (rnd_en && $urandom_range(0, 7) == 0) begin
                load = 1'b1; digits_in = 16'($urandom);
            end
            if (t % FRAME == FRAME - 1) begin
                if (load)        m_disp = digits_in;
                else if (m_pend) m_disp = m_shadow;
                m_pend = 1'b0;
            end else if (load) begin
                m_shadow = digits_in; m_pend = 1'b1;
            end
            t++;
        end
        @(negedge clk);
        load = 1'b0;
        t--;  // the extra negedge is re-checked by the next run call
        #0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_sel", 32'(digit_sel), 32'd0);
        chk("rst_fe",  32'(frame_end), 32'd0);
        rst_n = 1'b1;
        model_reset();
        // Frame 0 idle, 1234 loaded mid-frame 1, then 1111 superseded by 5678 at frame_end.
        sched[FRAME + 5]             = 16'h1234;
        sched[3 * FRAME + 3]         = 16'h1111;
        sched[3 * FRAME + FRAME - 1] = 16'h5678;
        sched[5 * FRAME + 7]         = 16'hA00F;
        sched[7 * FRAME + 9]         = 16'h0050;
        sched[9 * FRAME + 2]         = 16'h0000;
        run_frames();
    end

    task automatic run_frames();
        int c;
        // run with the extra-negedge compensation folded in: step one cycle at a time
        for (c = 0; c < 11 * FRAME; c++) step();
        rnd_en = 1;
        for (c = 0; c < 20 * FRAME; c++) step();
        rnd_en = 0;
        // Mid-frame reset during digit 2 SHOW with a load pending.
        sched.delete();
        while (t % FRAME != 2) step();
        sched[t] = 16'h9876;
        while (t % FRAME != 2 * SLOT + BK + 1) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", 32'(digit_sel), 32'd0);
        chk("midrst_bcd", 32'(bcd_out),   32'd0);
        chk("midrst_fe",  32'(frame_end), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sched.delete();
        for (c = 0; c < 3 * FRAME; c++) step();
        rnd_en = 1;
        for (c = 0; c < 10 * FRAME; c++) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    // One cycle: check at the current negedge, choose inputs, advance model, wait next negedge.
    task automatic step();
        check_outputs();
        load = 1'b0;
        if (sched.exists(t)) begin
            load = 1'b1; digits_in = sched[t];
        end else if (rnd_en && $urandom_range(0, 7) == 0) begin
            load = 1'b1; digits_in = 16'($urandom);
        end
        if (t % FRAME == FRAME - 1) begin
            if (load)        m_disp = digits_in;
            else if (m_pend) m_disp = m_shadow;
            m_pend = 1'b0;
        end else if (load) begin
            m_shadow = digits_in; m_pend = 1'b1;
        end
        t++;
        @(negedge clk);
    endtask
endmodule
